// File: rtl/note_chart_feeder_if.sv
// Bundle of control, chart-ROM and fret-write signals around note_chart_feeder.
// The slave modport is the feeder side; the master modport is the surrounding system.
interface note_chart_feeder_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              frame_tick;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic              write;
  logic [31:0]       data_in;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, pause, frame_tick, rom_data,
    input  rom_addr, write, data_in, busy, done
  );

  modport slave (
    input  start, stop, pause, frame_tick, rom_data,
    output rom_addr, write, data_in, busy, done
  );
endinterface

// File: rtl/note_chart_feeder.sv
// Chart sequencer: walks the note-chart ROM, waits per-entry frame delays and strobes note words to fret.
// Optional CHART_LOOP_EN: end of chart wraps to entry 0 instead of stopping in DONE.
module note_chart_feeder #(
  parameter int ADDR_W    = 10,
  parameter int CHART_LEN = 1024
) (
  input logic                clk,
  input logic                Reset,
  note_chart_feeder_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] DELAY = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_LEN - 1);

`ifdef CHART_LOOP_EN
  localparam logic [2:0] END_STATE = FETCH;
`else
  localparam logic [2:0] END_STATE = DONE;
`endif

  logic [2:0]        state;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       idx;
  logic [7:0]        cnt;
  logic [7:0]        hold;
  logic [4:0]        lane;
  logic              write;
  logic [31:0]       data_in;

  // write/data_in are registered on the edge that enters EMIT, so write is high exactly while in EMIT
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      idx      <= '0;
      cnt      <= '0;
      hold     <= '0;
      lane     <= '0;
      write    <= 1'b0;
      data_in  <= '0;
    end else begin
      write <= 1'b0;
      if (bus.stop) begin
        state    <= IDLE;
        rom_addr <= '0;
        idx      <= '0;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              state    <= FETCH;
              rom_addr <= '0;
              idx      <= '0;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            lane <= bus.rom_data[4:0];
            hold <= bus.rom_data[15:8];
            if (bus.rom_data == '0) begin
              state <= END_STATE;
`ifdef CHART_LOOP_EN
              rom_addr <= '0;
`endif
            end else if (bus.rom_data[23:16] == 8'd0) begin
              state   <= EMIT;
              write   <= 1'b1;
              data_in <= {idx, bus.rom_data[15:8], 3'b000, bus.rom_data[4:0]};
            end else begin
              state <= DELAY;
              cnt   <= bus.rom_data[23:16];
            end
          end
          DELAY: begin
            if (bus.frame_tick && !bus.pause) begin
              cnt <= cnt - 8'd1;
              if (cnt == 8'd1) begin
                state   <= EMIT;
                write   <= 1'b1;
                data_in <= {idx, hold, 3'b000, lane};
              end
            end
          end
          EMIT: begin
            idx <= idx + 16'd1;
            if (rom_addr == LAST_ADDR) begin
              state <= END_STATE;
`ifdef CHART_LOOP_EN
              rom_addr <= '0;
`endif
            end else begin
              state    <= FETCH;
              rom_addr <= rom_addr + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr = rom_addr;
  assign bus.write    = write;
  assign bus.data_in  = data_in;
  assign bus.busy     = (state != IDLE) && (state != DONE);
  assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_note_chart_feeder.sv
// Directed self-checking bench for note_chart_feeder with a registered-read chart ROM model.
module tb_note_chart_feeder;
  logic clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   failed = 0;
  logic [23:0] rom [16];

  always #5 clk = ~clk;

  note_chart_feeder_if #(.ADDR_W(4)) bus ();

  note_chart_feeder #(.ADDR_W(4), .CHART_LEN(4)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // ROM word appears one cycle after the address
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 24'h0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic tick(input logic paused);
    bus.frame_tick = 1'b1;
    bus.pause = paused;
    step();
    bus.frame_tick = 1'b0;
    bus.pause = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.pause = 1'b0;
    bus.frame_tick = 1'b0;
    bus.rom_data = 24'h0;
    clear_rom();
    step();
    step();
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_data", bus.data_in, 32'd0);
    check("rst_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    Reset = 1'b0;
    step();

`ifndef CHART_LOOP_EN
    // single zero-delay entry then end marker
    rom[0] = 24'h000315;
    pulse_start();
    check("t1_fetch_busy", 32'(bus.busy), 32'd1);
    check("t1_fetch_wr", 32'(bus.write), 32'd0);
    step();
    check("t1_load_wr", 32'(bus.write), 32'd0);
    step();
    check("t1_write", 32'(bus.write), 32'd1);
    check("t1_data", bus.data_in, 32'h0000_0315);
    step();
    check("t1_write_low", 32'(bus.write), 32'd0);
    step();
    step();
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_data_held", bus.data_in, 32'h0000_0315);

    // delay of 2 frames; a tick during FETCH and a start while busy are both ignored
    rom[0] = 24'h023215;
    pulse_start();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
    check("t2_delay_wr", 32'(bus.write), 32'd0);
    pulse_start();
    check("t2_start_ignored", 32'(bus.busy), 32'd1);
    tick(1'b0);
    check("t2_tick1_wr", 32'(bus.write), 32'd0);
    step();
    step();
    check("t2_idle_wr", 32'(bus.write), 32'd0);
    tick(1'b0);
    check("t2_write", 32'(bus.write), 32'd1);
    check("t2_data", bus.data_in, 32'h0000_3215);
    step();
    check("t2_write_low", 32'(bus.write), 32'd0);
    step();
    step();
    check("t2_done", 32'(bus.done), 32'd1);

    // paused tick is ignored
    pulse_start();
    step();
    step();
    tick(1'b1);
    check("t3_paused_wr", 32'(bus.write), 32'd0);
    tick(1'b0);
    check("t3_tick2_wr", 32'(bus.write), 32'd0);
    tick(1'b0);
    check("t3_write", 32'(bus.write), 32'd1);
    check("t3_data", bus.data_in, 32'h0000_3215);
    step();
    step();
    step();
    check("t3_done", 32'(bus.done), 32'd1);

    // three back-to-back zero-delay entries
    clear_rom();
    rom[0] = 24'h000001;
    rom[1] = 24'h000002;
    rom[2] = 24'h000004;
    pulse_start();
    check("t4_addr0", 32'(bus.rom_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      step();
      check($sformatf("t4_write%0d", k), 32'(bus.write), 32'd1);
      check($sformatf("t4_data%0d", k), bus.data_in, {16'(k), 8'h00, 3'b000, 5'(1 << k)});
      step();
      check($sformatf("t4_addr%0d", k + 1), 32'(bus.rom_addr), 32'(k + 1));
    end
    step();
    step();
    check("t4_done", 32'(bus.done), 32'd1);

    // CHART_LEN boundary: entry 3 is the last one, entry 4 must never be emitted
    rom[3] = 24'h000008;
    rom[4] = 24'h000010;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      check($sformatf("t5_data%0d", k), bus.data_in, {16'(k), 8'h00, 3'b000, 5'(1 << k)});
      step();
    end
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_addr", 32'(bus.rom_addr), 32'd3);
    check("t5_wr", 32'(bus.write), 32'd0);
`else
    // looping chart: entry 0 then end marker repeats with a rising index
    rom[0] = 24'h000001;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      step();
      step();
      check($sformatf("lp_data%0d", k), bus.data_in, {16'(k), 8'h00, 3'b000, 5'd1});
      check($sformatf("lp_write%0d", k), 32'(bus.write), 32'd1);
      step();
      step();
      step();
      check($sformatf("lp_addr%0d", k), 32'(bus.rom_addr), 32'd0);
      check($sformatf("lp_done%0d", k), 32'(bus.done), 32'd0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("lp_stop_busy", 32'(bus.busy), 32'd0);
`endif

    // stop in DELAY
    clear_rom();
    rom[0] = 24'h050001;
    pulse_start();
    step();
    step();
    check("t6_delay_busy", 32'(bus.busy), 32'd1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    check("t6_addr", 32'(bus.rom_addr), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0);
      check($sformatf("t6_nowr%0d", k), 32'(bus.write), 32'd0);
    end

    // stop beats the final tick that would enter EMIT
    rom[0] = 24'h010001;
    pulse_start();
    step();
    step();
    bus.stop = 1'b1;
    tick(1'b0);
    bus.stop = 1'b0;
    check("t7_stop_wr", 32'(bus.write), 32'd0);
    check("t7_stop_busy", 32'(bus.busy), 32'd0);

    // Reset while in EMIT of entry 1
    rom[0] = 24'h000003;
    rom[1] = 24'h000005;
    pulse_start();
    for (int k = 0; k < 5; k++) step();
    check("t8_write", 32'(bus.write), 32'd1);
    check("t8_data", bus.data_in, 32'h0001_0005);
    check("t8_addr", 32'(bus.rom_addr), 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t8_rst_write", 32'(bus.write), 32'd0);
    check("t8_rst_data", bus.data_in, 32'd0);
    check("t8_rst_addr", 32'(bus.rom_addr), 32'd0);
    check("t8_rst_busy", 32'(bus.busy), 32'd0);
    check("t8_rst_done", 32'(bus.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/note_chart_feeder.md
# note_chart_feeder

Chart sequencer that drives the fret renderer's `write`/`data_in` port. It walks a note-chart ROM one entry at a time and waits a per-entry number of video frames, counted on `frame_tick`. It then pulses `write` with a packed 32-bit note word. It sits between the chart memory and `fret`, clocked by the same pixel-domain clock as `vga_controller`.

## Interface
Parameters:
- `ADDR_W`, 10: chart ROM address width.
- `CHART_LEN`, 1024: number of valid ROM entries, ≤ 2^ADDR_W.

Ports (one clock; reset is synchronous and active-high, ports named `clk` and `Reset`):
- `clk`  in  1: system clock.
- `Reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin playback from entry 0; honoured only in IDLE or DONE.
- `stop`  in  1: abort playback; return to IDLE.
- `pause`  in  1: level; while high, `frame_tick` is ignored.
- `frame_tick`  in  1: one-cycle pulse per video frame (vsync-derived).
- `rom_addr`  out  ADDR_W: registered chart ROM address.
- `rom_data`  in  24: ROM word, valid one cycle after `rom_addr` changes.
  - [4:0] lane mask
  - [7:5] reserved
  - [15:8] hold duration in frames
  - [23:16] delay in frames before the event
- `write`  out  1: one-cycle strobe to `fret`.
- `data_in`  out  32: note word, valid while `write` is high, held afterwards.
  - [4:0] lane mask
  - [7:5] 0
  - [15:8] hold duration
  - [31:16] event index
- `busy`  out  1: high in every state except IDLE and DONE.
- `done`  out  1: high in DONE.

## Operation
- Reset values: state IDLE, `rom_addr`=0, `write`=0, `data_in`=0, `busy`=0, `done`=0; event index and delay counter are 0.
- States:
  - IDLE: on `start` → FETCH, with `rom_addr`=0 and index=0.
  - FETCH: one wait cycle for ROM latency → LOAD.
  - LOAD: capture `rom_data`.
    - Word == 24'h0 (end marker) → DONE.
    - Delay == 0 → EMIT.
    - Otherwise load the delay counter → DELAY.
  - DELAY: each `frame_tick` with `pause`=0 decrements the counter. The tick that takes it 1→0 moves to EMIT on the next edge.
  - EMIT: `write`=1 for exactly one cycle and `data_in` updated. Index increments. Then:
    - If `rom_addr` == CHART_LEN-1 → DONE.
    - Else `rom_addr`+1 → FETCH.
  - DONE: holds. `start` → FETCH from address 0 with index reset to 0.
- Stop and restart:
  - `stop` in any state → IDLE next edge; no `write` that cycle; `rom_addr` and index cleared.
  - `stop` has priority over `start` and over EMIT.
  - `start` while busy is ignored.
- Frame ticks: counted only in DELAY. Ticks in FETCH, LOAD or EMIT are dropped.
- Index is 16 bits and wraps modulo 2^16.
- `Reset` mid-playback: outputs return to reset values on the next edge. Any in-progress `write` is cancelled.

## Timing
- Latency from the edge that samples `start`: FETCH at +1, LOAD at +2, EMIT (`write` high) at +3 for a zero-delay entry.
- Nonzero delay D: `write` rises on the edge after the D-th counted `frame_tick`.
- Back-to-back zero-delay entries: one `write` every 3 cycles.
- `data_in` changes only on the edge that raises `write`.

## Configuration
- `CHART_LOOP_EN` defined: an end marker, or EMIT at CHART_LEN-1, wraps to FETCH at address 0 instead of DONE.
  - Index keeps counting.
  - `done` is never asserted; exit is via `stop` or `Reset` only.
- `CHART_LOOP_EN` undefined: behaviour as in Operation.

## Test plan
- ROM[0]=24'h000315, ROM[1]=0; pulse `start` → `write` high exactly 3 cycles later with `data_in`=32'h0000_0315, then `done`=1 and `busy`=0.
- ROM[0]=24'h02_32_15 (delay 2); give 2 `frame_tick`s → single `write` with `data_in`=32'h0000_3215 on the edge after the second tick; no `write` before it.
- Same entry, `pause`=1 during the first tick → that tick is ignored; `write` follows the third tick.
- Three zero-delay entries 0x01, 0x02, 0x04, then end marker → `write` at +3, +6, +9 with indices 0, 1, 2; `rom_addr` sequence 0, 1, 2, 3.
- `stop` asserted in DELAY → IDLE next cycle, `rom_addr`=0, no `write`. `Reset` asserted in EMIT → `write`=0 and all outputs at reset values.
- With `CHART_LOOP_EN`, ROM[0]=0x01, ROM[1]=end → `write` repeats on entry 0 with indices 0, 1, 2…; `done` stays 0.
